// File: rtl/load_store_queue.sv
// load_store_queue
//   Buffers address-resolved loads and stores between the memory reservation
//   station and a single dmem port. Stores sit in a circular store queue (SQ)
//   and drain to memory in program order once the ROB commits them. Loads sit
//   in a circular load queue (LQ), issue in order, forward from an older store
//   that fully covers them, and are discarded on flush.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               pipeline flush (mispredict)
//   iss_*               issue handshake and operands from the reservation station
//   commit_valid/_idx   ROB head is a store committing this cycle
//   dmem_*              word-aligned request (addr/rmask/wmask/wdata), rdata/resp back
//   wb_ld_*             load result to the CDB plus RVFI fields
//   wb_st_*             store marked done in the ROB plus RVFI fields
module load_store_queue #(
  parameter int LQ_DEPTH  = 4,
  parameter int SQ_DEPTH  = 4,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic                 iss_is_store,
  input  logic [2:0]           iss_funct3,
  input  logic [31:0]          iss_rs1_data,
  input  logic [31:0]          iss_imm,
  input  logic [31:0]          iss_rs2_data,
  input  logic [ROB_IDX_W-1:0] iss_rob_idx,
  input  logic [4:0]           iss_rd_addr,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp,
  output logic                 wb_ld_valid,
  output logic [ROB_IDX_W-1:0] wb_ld_rob_idx,
  output logic [4:0]           wb_ld_rd_addr,
  output logic [31:0]          wb_ld_data,
  output logic [31:0]          wb_ld_mem_addr,
  output logic [3:0]           wb_ld_rmask,
  output logic [31:0]          wb_ld_rdata,
  output logic                 wb_st_valid,
  output logic [ROB_IDX_W-1:0] wb_st_rob_idx,
  output logic [31:0]          wb_st_mem_addr,
  output logic [3:0]           wb_st_wmask,
  output logic [31:0]          wb_st_wdata
);
  localparam int LQ_AW = $clog2(LQ_DEPTH);
  localparam int SQ_AW = $clog2(SQ_DEPTH);

  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] base;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b001:  return 32'($signed(sh[15:0]));
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Pointers carry an extra wrap bit above the index.
  logic [SQ_AW:0] sq_head, sq_cmt, sq_tail, sq_cmt_nxt;
  logic [LQ_AW:0] lq_head, lq_tail;

  logic [29:0]          sq_word  [SQ_DEPTH];
  logic [3:0]           sq_wmask [SQ_DEPTH];
  logic [31:0]          sq_wdata [SQ_DEPTH];
  logic [ROB_IDX_W-1:0] sq_rob   [SQ_DEPTH];

  logic [29:0]          lq_word  [LQ_DEPTH];
  logic [3:0]           lq_rmask [LQ_DEPTH];
  logic [1:0]           lq_off   [LQ_DEPTH];
  logic [2:0]           lq_f3    [LQ_DEPTH];
  logic [ROB_IDX_W-1:0] lq_rob   [LQ_DEPTH];
  logic [4:0]           lq_rd    [LQ_DEPTH];
  logic [SQ_AW:0]       lq_snap  [LQ_DEPTH];

  logic req_busy, req_is_store, ld_killed;

  // ---- stage 0: issue decode, queue status, arbitration ----
  logic [31:0] iss_addr, iss_wdata;
  logic [3:0]  iss_mask;
  logic        sq_full, lq_full, lq_empty;
  logic        st_fire, ld_fire, commit_fire;
  logic [SQ_AW-1:0] sh_idx;
  logic [LQ_AW-1:0] lh_idx;

  assign iss_addr  = iss_rs1_data + iss_imm;
  assign iss_mask  = byte_mask(iss_funct3, iss_addr[1:0]);
  assign iss_wdata = iss_rs2_data << {iss_addr[1:0], 3'b000};

  assign sq_full  = (sq_head[SQ_AW-1:0] == sq_tail[SQ_AW-1:0]) && (sq_head[SQ_AW] != sq_tail[SQ_AW]);
  assign lq_full  = (lq_head[LQ_AW-1:0] == lq_tail[LQ_AW-1:0]) && (lq_head[LQ_AW] != lq_tail[LQ_AW]);
  assign lq_empty = (lq_head == lq_tail);

  assign iss_ready = !rst && !flush && (iss_is_store ? !sq_full : !lq_full);
  assign st_fire   = iss_valid && iss_ready && iss_is_store;
  assign ld_fire   = iss_valid && iss_ready && !iss_is_store;

  assign sh_idx = sq_head[SQ_AW-1:0];
  assign lh_idx = lq_head[LQ_AW-1:0];

  // Commit applies only to the oldest uncommitted store, and only if the tag agrees.
  assign commit_fire = commit_valid && (sq_cmt != sq_tail) &&
                       (commit_rob_idx == sq_rob[sq_cmt[SQ_AW-1:0]]);
  assign sq_cmt_nxt  = sq_cmt + {{SQ_AW{1'b0}}, commit_fire};

  // Older stores for the LQ head are SQ head .. snapshot-1. Scanning oldest to
  // youngest and letting later matches win picks the youngest overlapping store.
  logic             fwd_hit, fwd_cover;
  logic [SQ_AW-1:0] fwd_idx;
  logic [SQ_AW:0]   older_cnt, scan_ptr;
  logic [3:0]       ovl;

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_cover = 1'b0;
    fwd_idx   = '0;
    scan_ptr  = '0;
    ovl       = '0;
    older_cnt = lq_snap[lh_idx] - sq_head;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      scan_ptr = sq_head + (SQ_AW+1)'(i);
      ovl      = sq_wmask[scan_ptr[SQ_AW-1:0]] & lq_rmask[lh_idx];
      if (((SQ_AW+1)'(i) < older_cnt) && (sq_word[scan_ptr[SQ_AW-1:0]] == lq_word[lh_idx]) &&
          (ovl != 4'd0)) begin
        fwd_hit   = 1'b1;
        fwd_cover = (ovl == lq_rmask[lh_idx]);
        fwd_idx   = scan_ptr[SQ_AW-1:0];
      end
    end
  end

  logic ld_outstanding, st_issue, ld_issue, fwd_go, resp_fire, st_pop, ld_resp_ok, lq_pop;

  assign ld_outstanding = req_busy && !req_is_store;
  assign st_issue   = !req_busy && (sq_head != sq_cmt);
  assign ld_issue   = !req_busy && !st_issue && !lq_empty && !fwd_hit && !flush;
  assign fwd_go     = !lq_empty && !ld_outstanding && fwd_hit && fwd_cover && !flush;
  assign resp_fire  = req_busy && dmem_resp;
  assign st_pop     = resp_fire && req_is_store;
  assign ld_resp_ok = resp_fire && !req_is_store && !ld_killed && !flush;
  assign lq_pop     = ld_resp_ok || fwd_go;

  // ---- stage 1: queue storage (data only) ----
  always_ff @(posedge clk) begin
    if (st_fire) begin
      sq_word[sq_tail[SQ_AW-1:0]]  <= iss_addr[31:2];
      sq_wmask[sq_tail[SQ_AW-1:0]] <= iss_mask;
      sq_wdata[sq_tail[SQ_AW-1:0]] <= iss_wdata;
      sq_rob[sq_tail[SQ_AW-1:0]]   <= iss_rob_idx;
    end
    if (ld_fire) begin
      lq_word[lq_tail[LQ_AW-1:0]]  <= iss_addr[31:2];
      lq_rmask[lq_tail[LQ_AW-1:0]] <= iss_mask;
      lq_off[lq_tail[LQ_AW-1:0]]   <= iss_addr[1:0];
      lq_f3[lq_tail[LQ_AW-1:0]]    <= iss_funct3;
      lq_rob[lq_tail[LQ_AW-1:0]]   <= iss_rob_idx;
      lq_rd[lq_tail[LQ_AW-1:0]]    <= iss_rd_addr;
      lq_snap[lq_tail[LQ_AW-1:0]]  <= sq_tail;
    end
  end

  // ---- stage 1: pointers, dmem request, writeback registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_head <= '0; sq_cmt <= '0; sq_tail <= '0;
      lq_head <= '0; lq_tail <= '0;
      req_busy <= 1'b0; req_is_store <= 1'b0; ld_killed <= 1'b0;
      dmem_addr <= '0; dmem_rmask <= '0; dmem_wmask <= '0; dmem_wdata <= '0;
      wb_ld_valid <= 1'b0; wb_ld_rob_idx <= '0; wb_ld_rd_addr <= '0; wb_ld_data <= '0;
      wb_ld_mem_addr <= '0; wb_ld_rmask <= '0; wb_ld_rdata <= '0;
      wb_st_valid <= 1'b0; wb_st_rob_idx <= '0; wb_st_mem_addr <= '0;
      wb_st_wmask <= '0; wb_st_wdata <= '0;
    end else begin
      // Flush rolls the tail back to the first uncommitted store; committed ones keep draining.
      sq_cmt  <= sq_cmt_nxt;
      sq_tail <= flush ? sq_cmt_nxt : sq_tail + {{SQ_AW{1'b0}}, st_fire};
      sq_head <= sq_head + {{SQ_AW{1'b0}}, st_pop};
      if (flush) begin
        lq_head <= '0;
        lq_tail <= '0;
      end else begin
        lq_head <= lq_head + {{LQ_AW{1'b0}}, lq_pop};
        lq_tail <= lq_tail + {{LQ_AW{1'b0}}, ld_fire};
      end

      if (resp_fire) begin
        req_busy   <= 1'b0;
        dmem_rmask <= 4'd0;
        dmem_wmask <= 4'd0;
        ld_killed  <= 1'b0;
      end else if (st_issue) begin
        req_busy     <= 1'b1;
        req_is_store <= 1'b1;
        dmem_addr    <= {sq_word[sh_idx], 2'b00};
        dmem_rmask   <= 4'd0;
        dmem_wmask   <= sq_wmask[sh_idx];
        dmem_wdata   <= sq_wdata[sh_idx];
      end else if (ld_issue) begin
        req_busy     <= 1'b1;
        req_is_store <= 1'b0;
        dmem_addr    <= {lq_word[lh_idx], 2'b00};
        dmem_rmask   <= lq_rmask[lh_idx];
        dmem_wmask   <= 4'd0;
        dmem_wdata   <= 32'd0;
      end
      // A flushed in-flight load still has to consume its response, but silently.
      if (flush && ld_outstanding && !resp_fire) ld_killed <= 1'b1;

      wb_st_valid <= st_fire;
      if (st_fire) begin
        wb_st_rob_idx  <= iss_rob_idx;
        wb_st_mem_addr <= {iss_addr[31:2], 2'b00};
        wb_st_wmask    <= iss_mask;
        wb_st_wdata    <= iss_wdata;
      end

      wb_ld_valid <= lq_pop;
      if (lq_pop) begin
        wb_ld_rob_idx  <= lq_rob[lh_idx];
        wb_ld_rd_addr  <= lq_rd[lh_idx];
        wb_ld_mem_addr <= {lq_word[lh_idx], 2'b00};
        wb_ld_rmask    <= lq_rmask[lh_idx];
      end
      if (ld_resp_ok) begin
        wb_ld_rdata <= dmem_rdata;
        wb_ld_data  <= load_extend(dmem_rdata, lq_off[lh_idx], lq_f3[lh_idx]);
      end else if (fwd_go) begin
        wb_ld_rdata <= sq_wdata[fwd_idx];
        wb_ld_data  <= load_extend(sq_wdata[fwd_idx], lq_off[lh_idx], lq_f3[lh_idx]);
      end
    end
  end
endmodule

// File: tb/tb_load_store_queue.sv
// tb_load_store_queue
//   Directed bench for load_store_queue: stores with commit/drain, store-to-load
//   forwarding, partial-overlap stall, load extension, queue full, flush
//   behaviour and pointer wrap-around. The bench acts as the memory and the ROB.
module tb_load_store_queue;
  logic        clk = 1'b0;
  logic        rst, flush, iss_valid, iss_ready, iss_is_store;
  logic [2:0]  iss_funct3;
  logic [31:0] iss_rs1_data, iss_imm, iss_rs2_data;
  logic [3:0]  iss_rob_idx;
  logic [4:0]  iss_rd_addr;
  logic        commit_valid;
  logic [3:0]  commit_rob_idx;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic        wb_ld_valid, wb_st_valid;
  logic [3:0]  wb_ld_rob_idx, wb_st_rob_idx, wb_ld_rmask, wb_st_wmask;
  logic [4:0]  wb_ld_rd_addr;
  logic [31:0] wb_ld_data, wb_ld_mem_addr, wb_ld_rdata, wb_st_mem_addr, wb_st_wdata;

  load_store_queue #(.LQ_DEPTH(4), .SQ_DEPTH(4), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_is_store(iss_is_store),
    .iss_funct3(iss_funct3), .iss_rs1_data(iss_rs1_data), .iss_imm(iss_imm),
    .iss_rs2_data(iss_rs2_data), .iss_rob_idx(iss_rob_idx), .iss_rd_addr(iss_rd_addr),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .wb_ld_valid(wb_ld_valid), .wb_ld_rob_idx(wb_ld_rob_idx), .wb_ld_rd_addr(wb_ld_rd_addr),
    .wb_ld_data(wb_ld_data), .wb_ld_mem_addr(wb_ld_mem_addr), .wb_ld_rmask(wb_ld_rmask),
    .wb_ld_rdata(wb_ld_rdata),
    .wb_st_valid(wb_st_valid), .wb_st_rob_idx(wb_st_rob_idx), .wb_st_mem_addr(wb_st_mem_addr),
    .wb_st_wmask(wb_st_wmask), .wb_st_wdata(wb_st_wdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_iss(input logic st, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2,
                           input logic [3:0] rob, input logic [4:0] rd);
    iss_is_store = st; iss_funct3 = f3; iss_rs1_data = rs1; iss_imm = imm;
    iss_rs2_data = rs2; iss_rob_idx = rob; iss_rd_addr = rd; iss_valid = 1'b1;
    #1 check("iss_ready_accept", 32'(iss_ready), 32'd1);
  endtask

  // sw, commit, then serve the dmem write
  task automatic store_drain(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rob);
    drive_iss(1'b1, 3'b010, addr, 32'd0, data, rob, 5'd0);
    tick();
    check("drain_wb_st_valid", 32'(wb_st_valid), 32'd1);
    check("drain_wb_st_wdata", wb_st_wdata, data);
    iss_valid = 1'b0; commit_valid = 1'b1; commit_rob_idx = rob;
    tick();
    commit_valid = 1'b0;
    tick();
    check("drain_wmask", 32'(dmem_wmask), 32'hF);
    check("drain_addr", dmem_addr, addr);
    check("drain_wdata", dmem_wdata, data);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("drain_wmask_clear", 32'(dmem_wmask), 32'd0);
  endtask

  // load served by dmem with no older stores in the way
  task automatic do_load(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic [3:0] rob, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [3:0] exp_rmask, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    drive_iss(1'b0, f3, rs1, imm, 32'd0, rob, rd);
    tick();
    iss_valid = 1'b0;
    tick();
    check("ld_rmask", 32'(dmem_rmask), 32'(exp_rmask));
    check("ld_addr", dmem_addr, exp_addr);
    dmem_rdata = rdata; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("ld_wb_valid", 32'(wb_ld_valid), 32'd1);
    check("ld_wb_data", wb_ld_data, exp_data);
    check("ld_wb_rd", 32'(wb_ld_rd_addr), 32'(rd));
    check("ld_wb_rob", 32'(wb_ld_rob_idx), 32'(rob));
    check("ld_wb_rdata", wb_ld_rdata, rdata);
    tick();
    check("ld_wb_pulse", 32'(wb_ld_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_is_store = 1'b0; iss_funct3 = 3'd0;
    iss_rs1_data = 32'd0; iss_imm = 32'd0; iss_rs2_data = 32'd0; iss_rob_idx = 4'd0;
    iss_rd_addr = 5'd0; commit_valid = 1'b0; commit_rob_idx = 4'd0;
    dmem_rdata = 32'd0; dmem_resp = 1'b0;
    tick(); tick();
    check("rst_iss_ready", 32'(iss_ready), 32'd0);
    check("rst_wb_ld_valid", 32'(wb_ld_valid), 32'd0);
    check("rst_wb_st_valid", 32'(wb_st_valid), 32'd0);
    check("rst_dmem_rmask", 32'(dmem_rmask), 32'd0);
    check("rst_dmem_wmask", 32'(dmem_wmask), 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_wb_ld_data", wb_ld_data, 32'd0);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(iss_ready), 32'd1);

    // sw 0xDEADBEEF @0x100, commit, drain
    drive_iss(1'b1, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 4'd1, 5'd0);
    tick();
    check("t1_wb_st_valid", 32'(wb_st_valid), 32'd1);
    check("t1_wb_st_addr", wb_st_mem_addr, 32'h100);
    check("t1_wb_st_wmask", 32'(wb_st_wmask), 32'hF);
    check("t1_wb_st_rob", 32'(wb_st_rob_idx), 32'd1);
    iss_valid = 1'b0; commit_valid = 1'b1; commit_rob_idx = 4'd1;
    tick();
    commit_valid = 1'b0;
    check("t1_wb_st_pulse", 32'(wb_st_valid), 32'd0);
    check("t1_no_req_yet", 32'(dmem_wmask), 32'd0);
    tick();
    check("t1_wmask", 32'(dmem_wmask), 32'hF);
    check("t1_addr", dmem_addr, 32'h100);
    check("t1_wdata", dmem_wdata, 32'hDEADBEEF);
    check("t1_rmask", 32'(dmem_rmask), 32'd0);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("t1_wmask_clear", 32'(dmem_wmask), 32'd0);

    // sw 0x11223344 @0x200 uncommitted, lbu @0x202 forwards 0x22
    drive_iss(1'b1, 3'b010, 32'h200, 32'd0, 32'h11223344, 4'd2, 5'd0);
    tick();
    check("t2_wb_st_valid", 32'(wb_st_valid), 32'd1);
    drive_iss(1'b0, 3'b100, 32'h200, 32'd2, 32'd0, 4'd3, 5'd5);
    tick();
    iss_valid = 1'b0;
    check("t2_no_read_a", 32'(dmem_rmask), 32'd0);
    tick();
    check("t2_wb_ld_valid", 32'(wb_ld_valid), 32'd1);
    check("t2_wb_ld_data", wb_ld_data, 32'h22);
    check("t2_wb_ld_rmask", 32'(wb_ld_rmask), 32'b0100);
    check("t2_wb_ld_addr", wb_ld_mem_addr, 32'h200);
    check("t2_wb_ld_rd", 32'(wb_ld_rd_addr), 32'd5);
    check("t2_no_read_b", 32'(dmem_rmask), 32'd0);
    tick();
    check("t2_wb_ld_pulse", 32'(wb_ld_valid), 32'd0);
    flush = 1'b1;
    #1 check("t2_flush_ready", 32'(iss_ready), 32'd0);
    tick();
    flush = 1'b0;

    // sb 0x80 @0x301 uncommitted, lw @0x300 waits for the store to drain
    drive_iss(1'b1, 3'b000, 32'h300, 32'd1, 32'h80, 4'd4, 5'd0);
    tick();
    check("t3_wb_st_wmask", 32'(wb_st_wmask), 32'b0010);
    check("t3_wb_st_wdata", wb_st_wdata, 32'h8000);
    check("t3_wb_st_addr", wb_st_mem_addr, 32'h300);
    drive_iss(1'b0, 3'b010, 32'h300, 32'd0, 32'd0, 4'd5, 5'd6);
    tick();
    iss_valid = 1'b0;
    tick();
    check("t3_wait_rmask_a", 32'(dmem_rmask), 32'd0);
    check("t3_wait_wmask_a", 32'(dmem_wmask), 32'd0);
    tick();
    check("t3_wait_rmask_b", 32'(dmem_rmask), 32'd0);
    check("t3_wait_wb", 32'(wb_ld_valid), 32'd0);
    commit_valid = 1'b1; commit_rob_idx = 4'd4;
    tick();
    commit_valid = 1'b0;
    tick();
    check("t3_st_wmask", 32'(dmem_wmask), 32'b0010);
    check("t3_st_wdata", dmem_wdata, 32'h8000);
    check("t3_st_addr", dmem_addr, 32'h300);
    check("t3_st_rmask", 32'(dmem_rmask), 32'd0);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("t3_st_clear", 32'(dmem_wmask), 32'd0);
    check("t3_ld_not_yet", 32'(dmem_rmask), 32'd0);
    tick();
    check("t3_ld_rmask", 32'(dmem_rmask), 32'hF);
    check("t3_ld_addr", dmem_addr, 32'h300);
    dmem_rdata = 32'hCAFE8000; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("t3_wb_valid", 32'(wb_ld_valid), 32'd1);
    check("t3_wb_data", wb_ld_data, 32'hCAFE8000);
    check("t3_wb_rob", 32'(wb_ld_rob_idx), 32'd5);
    tick();

    // load width / extension
    do_load(3'b001, 32'h400, 32'd6, 4'd6, 5'd7, 32'h80010000, 4'b1100, 32'h404, 32'hFFFF8001);
    do_load(3'b101, 32'h400, 32'd6, 4'd7, 5'd8, 32'h80010000, 4'b1100, 32'h404, 32'h00008001);
    do_load(3'b000, 32'h400, 32'd7, 4'd8, 5'd9, 32'h80123456, 4'b1000, 32'h404, 32'hFFFFFF80);
    do_load(3'b100, 32'h400, 32'd1, 4'd9, 5'd10, 32'h0000AB00, 4'b0010, 32'h400, 32'h000000AB);
    do_load(3'b010, 32'h410, 32'hFFFFFFF0, 4'd10, 5'd11, 32'h12345678, 4'hF, 32'h400, 32'h12345678);

    // fill LQ with the first load stuck in dmem; stores still accepted; flush drops the read
    for (int k = 0; k < 4; k++) begin
      drive_iss(1'b0, 3'b010, 32'h800 + 32'(16 * k), 32'd0, 32'd0, 4'(k + 1), 5'(k + 1));
      tick();
    end
    iss_valid = 1'b0; iss_is_store = 1'b0;
    #1 check("t5_lq_full_ready", 32'(iss_ready), 32'd0);
    check("t5_rd_outstanding", 32'(dmem_rmask), 32'hF);
    check("t5_rd_addr", dmem_addr, 32'h800);
    drive_iss(1'b1, 3'b010, 32'h500, 32'd0, 32'h99, 4'd9, 5'd0);
    tick();
    check("t5_st_while_full", 32'(wb_st_valid), 32'd1);
    iss_valid = 1'b0; flush = 1'b1;
    #1 check("t5_flush_ready", 32'(iss_ready), 32'd0);
    tick();
    flush = 1'b0; iss_is_store = 1'b0;
    #1 check("t5_lq_empty_ready", 32'(iss_ready), 32'd1);
    check("t5_rd_held", 32'(dmem_rmask), 32'hF);
    dmem_rdata = 32'h55; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    check("t5_resp_no_wb", 32'(wb_ld_valid), 32'd0);
    check("t5_rmask_clear", 32'(dmem_rmask), 32'd0);
    tick();
    check("t5_no_wb_later", 32'(wb_ld_valid), 32'd0);
    check("t5_no_new_read", 32'(dmem_rmask), 32'd0);
    do_load(3'b100, 32'h900, 32'd3, 4'd1, 5'd12, 32'h7F000000, 4'b1000, 32'h900, 32'h7F);

    // two stores, commit the first (same cycle as second enqueue), flush
    drive_iss(1'b1, 3'b010, 32'h600, 32'd0, 32'hA5A5A5A5, 4'd10, 5'd0);
    tick();
    check("t6_s1_wb", 32'(wb_st_rob_idx), 32'd10);
    drive_iss(1'b1, 3'b010, 32'h604, 32'd0, 32'h5A5A5A5A, 4'd11, 5'd0);
    commit_valid = 1'b1; commit_rob_idx = 4'd10;
    tick();
    commit_valid = 1'b0;
    check("t6_s2_wb_valid", 32'(wb_st_valid), 32'd1);
    check("t6_s2_wb_rob", 32'(wb_st_rob_idx), 32'd11);
    iss_rs1_data = 32'h608; iss_rs2_data = 32'h77; iss_rob_idx = 4'd12;
    flush = 1'b1;
    #1 check("t6_flush_ready", 32'(iss_ready), 32'd0);
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check("t6_flush_drops_enq", 32'(wb_st_valid), 32'd0);
    check("t6_s1_wmask", 32'(dmem_wmask), 32'hF);
    check("t6_s1_addr", dmem_addr, 32'h600);
    check("t6_s1_wdata", dmem_wdata, 32'hA5A5A5A5);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t6_s2_never_w", 32'(dmem_wmask), 32'd0);
      check("t6_s2_never_r", 32'(dmem_rmask), 32'd0);
      tick();
    end

    // pointer wrap-around
    for (int k = 0; k < 12; k++)
      store_drain(32'h1000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'(k));
    for (int k = 0; k < 8; k++)
      do_load(3'b010, 32'h2000 + 32'(4 * k), 32'd0, 4'(k), 5'(k + 1), 32'hF0000000 + 32'(k),
              4'hF, 32'h2000 + 32'(4 * k), 32'hF0000000 + 32'(k));

    // forward after wrap: sw 0x89ABCDEF @0x3000, lh @0x3002 -> 0xFFFF89AB
    drive_iss(1'b1, 3'b010, 32'h3000, 32'd0, 32'h89ABCDEF, 4'd3, 5'd0);
    tick();
    drive_iss(1'b0, 3'b001, 32'h3000, 32'd2, 32'd0, 4'd4, 5'd13);
    tick();
    iss_valid = 1'b0;
    tick();
    check("t7_fwd_valid", 32'(wb_ld_valid), 32'd1);
    check("t7_fwd_data", wb_ld_data, 32'hFFFF89AB);
    check("t7_fwd_no_read", 32'(dmem_rmask), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("t7_flushed_no_write", 32'(dmem_wmask), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
